// File: rtl/spi_bus_bridge.sv
// rtl/spi_bus_bridge.sv - SPI mode-0 slave bridging an external master onto the register bus
// Optional feature macro: SPI_BRIDGE_BURST_EN (multi-frame bursts with address auto-increment)
module spi_bus_bridge #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_clk_i,
    input  logic              spi_ncs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic [DATA_W-1:0] b_data_o,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_wr_o,
    output logic              b_rd_o
);
    localparam int CMD_W   = ADDR_W + 1;
    localparam int FRAME_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
`ifdef SPI_BRIDGE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, WR, RD, HALT} state_t;

    logic [1:0] sck_sync;
    logic [1:0] ncs_sync;
    logic [1:0] mosi_sync;
    logic       sck_hist;
    logic       ncs_hist;

    // nCS chain resets low so a select held low through reset never counts as "seen high"
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync  <= '0;
            ncs_sync  <= '0;
            mosi_sync <= '0;
            sck_hist  <= 1'b0;
            ncs_hist  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_clk_i};
            ncs_sync  <= {ncs_sync[0], spi_ncs_i};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};
            sck_hist  <= sck_sync[1];
            ncs_hist  <= ncs_sync[1];
        end
    end

    logic rise_p;
    logic fall_p;
    logic cs_high;
    assign rise_p  = sck_sync[1] & ~sck_hist;
    assign fall_p  = ~sck_sync[1] & sck_hist;
    assign cs_high = ncs_hist;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shift_in;
    logic [FRAME_W-1:0] shift_next;
    logic [DATA_W-1:0]  shift_out;
    logic [DATA_W-1:0]  rd_buf;
    logic               wr_pend;
    logic               rd_pend;
    logic               rd_cap;
    logic               load_pend;
    logic               armed;

    assign shift_next = {shift_in[FRAME_W-2:0], mosi_sync[1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_in   <= '0;
            shift_out  <= '0;
            rd_buf     <= '0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            rd_cap     <= 1'b0;
            load_pend  <= 1'b0;
            armed      <= 1'b0;
            b_addr_o   <= '0;
            b_data_o   <= '0;
            b_wr_o     <= 1'b0;
            b_rd_o     <= 1'b0;
            spi_miso_o <= 1'b0;
        end else begin
            // Strobes fire one cycle after the frame action that requested them
            b_wr_o  <= wr_pend;
            b_rd_o  <= rd_pend;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            rd_cap  <= b_rd_o;
            if (rd_cap)
                rd_buf <= b_data_i;
            if (b_wr_o && BURST)
                b_addr_o <= b_addr_o + ADDR_W'(1);

            if (cs_high) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                shift_in   <= '0;
                shift_out  <= '0;
                load_pend  <= 1'b0;
                armed      <= 1'b1;
                spi_miso_o <= 1'b0;
            end else begin
                spi_miso_o <= (state == RD) ? shift_out[DATA_W-1] : 1'b0;
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state    <= CMD;
                            bit_cnt  <= '0;
                            shift_in <= '0;
                        end
                    end
                    CMD: begin
                        if (rise_p) begin
                            shift_in <= shift_next;
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt  <= '0;
                                b_addr_o <= shift_next[ADDR_W-1:0];
                                if (shift_next[CMD_W-1]) begin
                                    state     <= RD;
                                    rd_pend   <= 1'b1;
                                    load_pend <= 1'b1;
                                end else begin
                                    state <= WR;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    WR: begin
                        if (rise_p) begin
                            shift_in <= shift_next;
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt  <= '0;
                                b_data_o <= shift_next[DATA_W-1:0];
                                wr_pend  <= 1'b1;
                                if (!BURST)
                                    state <= HALT;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    RD: begin
                        // First falling edge after a frame boundary presents the new word
                        if (fall_p) begin
                            if (load_pend) begin
                                shift_out <= rd_buf;
                                load_pend <= 1'b0;
                            end else begin
                                shift_out <= {shift_out[DATA_W-2:0], 1'b0};
                            end
                        end
                        if (rise_p) begin
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                if (BURST) begin
                                    b_addr_o  <= b_addr_o + ADDR_W'(1);
                                    rd_pend   <= 1'b1;
                                    load_pend <= 1'b1;
                                end else begin
                                    state <= HALT;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_bus_bridge.sv
// tb/tb_spi_bus_bridge.sv - directed self-checking bench for spi_bus_bridge
module tb_spi_bus_bridge;
`ifdef SPI_BRIDGE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic       spi_ncs;
    logic       spi_mosi;
    logic       spi_miso;
    logic [6:0] b_addr;
    logic [7:0] b_data_w;
    logic [7:0] b_data_r = 8'h00;
    logic       b_wr;
    logic       b_rd;

    spi_bus_bridge #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .spi_clk_i  (spi_clk),
        .spi_ncs_i  (spi_ncs),
        .spi_mosi_i (spi_mosi),
        .spi_miso_o (spi_miso),
        .b_addr_o   (b_addr),
        .b_data_o   (b_data_w),
        .b_data_i   (b_data_r),
        .b_wr_o     (b_wr),
        .b_rd_o     (b_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [128];
    int wr_n = 0;
    int rd_n = 0;
    int both_n = 0;
    int wr_a [64];
    int wr_d [64];
    int wr_c [64];
    int rd_a [64];
    int rd_c [64];

    always @(negedge clk) begin
        if (b_wr && wr_n < 64) begin
            wr_a[wr_n] <= int'(b_addr);
            wr_d[wr_n] <= int'(b_data_w);
            wr_c[wr_n] <= cyc;
            wr_n       <= wr_n + 1;
        end
        if (b_rd && rd_n < 64) begin
            rd_a[rd_n] <= int'(b_addr);
            rd_c[rd_n] <= cyc;
            rd_n       <= rd_n + 1;
            b_data_r   <= mem[b_addr];
        end
        if (b_wr && b_rd)
            both_n <= both_n + 1;
    end

    int n_tests = 0;
    int n_fail = 0;
    int last_rise = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] v, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            repeat (6) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_clk = 1'b1;
            last_rise = cyc;
            repeat (6) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_ncs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] rx1;
        int wb;
        int rb;
        int t0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[3]    = 8'h3C;
        mem[16]   = 8'hAA;
        mem[17]   = 8'h55;
        rst      = 1'b1;
        spi_ncs  = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_addr", b_addr, 0);
        check("rst_data", b_data_w, 0);
        check("rst_wr", b_wr, 0);
        check("rst_rd", b_rd, 0);
        check("rst_miso", spi_miso, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // single write
        wb = wr_n;
        cs_low();
        send_frame(8'h05, 8, rx);
        send_frame(8'hA5, 8, rx);
        t0 = last_rise;
        cs_high();
        check("sw_count", wr_n - wb, 1);
        check("sw_addr", wr_a[wb], 8'h05);
        check("sw_data", wr_d[wb], 8'hA5);
        check("sw_latency", wr_c[wb] - t0, 4);
        check("sw_addr_after", b_addr, BURST ? 8'h06 : 8'h05);

        // single read
        rb = rd_n;
        cs_low();
        send_frame(8'h83, 8, rx);
        t0 = last_rise;
        send_frame(8'h00, 8, rx);
        cs_high();
        check("sr_count", rd_n - rb, BURST ? 2 : 1);
        check("sr_addr", rd_a[rb], 8'h03);
        check("sr_latency", rd_c[rb] - t0, 4);
        check("sr_miso", rx, 8'h3C);

        // burst write with address wrap
        wb = wr_n;
        cs_low();
        send_frame(8'h7E, 8, rx);
        send_frame(8'h11, 8, rx);
        send_frame(8'h22, 8, rx);
        send_frame(8'h33, 8, rx);
        cs_high();
        check("bw_count", wr_n - wb, BURST ? 3 : 1);
        check("bw0_addr", wr_a[wb], 8'h7E);
        check("bw0_data", wr_d[wb], 8'h11);
`ifdef SPI_BRIDGE_BURST_EN
        check("bw1_addr", wr_a[wb+1], 8'h7F);
        check("bw1_data", wr_d[wb+1], 8'h22);
        check("bw2_addr", wr_a[wb+2], 8'h00);
        check("bw2_data", wr_d[wb+2], 8'h33);
`endif

        // burst read
        rb = rd_n;
        cs_low();
        send_frame(8'h90, 8, rx);
        send_frame(8'h00, 8, rx);
        send_frame(8'h00, 8, rx1);
        cs_high();
        check("br_count", rd_n - rb, BURST ? 3 : 1);
        check("br0_addr", rd_a[rb], 8'h10);
        check("br_miso0", rx, 8'hAA);
        check("br_miso1", rx1, BURST ? 8'h55 : 8'h00);
`ifdef SPI_BRIDGE_BURST_EN
        check("br1_addr", rd_a[rb+1], 8'h11);
        check("br2_addr", rd_a[rb+2], 8'h12);
`endif

        // abort mid data frame, then a clean write
        wb = wr_n;
        cs_low();
        send_frame(8'h20, 8, rx);
        send_frame(8'h1F, 5, rx);
        cs_high();
        check("ab_count", wr_n - wb, 0);
        cs_low();
        send_frame(8'h01, 8, rx);
        send_frame(8'hFF, 8, rx);
        cs_high();
        check("ab_next_count", wr_n - wb, 1);
        check("ab_next_addr", wr_a[wb], 8'h01);
        check("ab_next_data", wr_d[wb], 8'hFF);

        // reset mid-transfer; no restart until nCS goes high then low
        wb = wr_n;
        cs_low();
        send_frame(8'h00, 4, rx);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mr_addr", b_addr, 0);
        check("mr_data", b_data_w, 0);
        check("mr_wr", b_wr, 0);
        check("mr_rd", b_rd, 0);
        check("mr_miso", spi_miso, 0);
        rst = 1'b0;
        send_frame(8'h0A, 8, rx);
        send_frame(8'h5A, 8, rx);
        cs_high();
        check("mr_unarmed_count", wr_n - wb, 0);
        cs_low();
        send_frame(8'h0A, 8, rx);
        send_frame(8'h5A, 8, rx);
        cs_high();
        check("mr_after_count", wr_n - wb, 1);
        check("mr_after_addr", wr_a[wb], 8'h0A);
        check("mr_after_data", wr_d[wb], 8'h5A);

        check("rd_wr_exclusive", both_n, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
